// File: rtl/ay_bus_writer.sv
// Queued AY-3-8910/YM2149 register writer: each (reg, val) entry is replayed as an
// address-latch phase then a data-write phase, paced by the AY clock enable.
module ay_bus_writer #(
    parameter int FIFO_AW = 4,
    parameter int HOLD_CE = 1,
    parameter int GAP_CE  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       wr_stb,
    input  logic [3:0] wr_reg,
    input  logic [7:0] wr_val,
    input  logic [3:0] rd_reg,
    output logic [7:0] rd_val,
    output logic [1:0] ay_address,
    output logic [7:0] ay_data,
    output logic       ay_wren,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CE - 1);
    localparam logic [3:0] GAP_LAST  = (GAP_CE > 0) ? 4'(GAP_CE - 1) : 4'd0;
    localparam logic       GAP_ZERO  = (GAP_CE == 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        GAP1  = 3'd2,
        WRITE = 3'd3,
        GAP2  = 3'd4
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [3:0]        cnt_r, cnt_nxt_s;
    logic [FIFO_AW:0]  wr_ptr_r, rd_ptr_r;
    logic [11:0]       mem_r [DEPTH];
    logic [11:0]       head_s;
    logic              empty_s, full_s, push_s, pop_s;
    logic [3:0]        hold_reg_r;
    logic [7:0]        hold_val_r;
    logic [7:0]        shadow_r [16];
    logic              shadow_we_s;
    logic              hold_done_s, gap_done_s;
    logic [1:0]        addr_nxt_s, ay_address_r;
    logic [7:0]        data_nxt_s, ay_data_r;
    logic              wren_nxt_s, ay_wren_r;
    logic [7:0]        rd_val_r;
    logic              overflow_r;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[FIFO_AW] != rd_ptr_r[FIFO_AW]) &&
                     (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_r[FIFO_AW-1:0]);
    // Full is judged before any same-clk pop, so a write into a full queue always drops.
    assign push_s  = wr_stb && !full_s;
    assign head_s  = mem_r[rd_ptr_r[FIFO_AW-1:0]];

    assign hold_done_s = ce && (cnt_r == HOLD_LAST);
    assign gap_done_s  = GAP_ZERO || (ce && (cnt_r == GAP_LAST));

    assign rd_val     = rd_val_r;
    assign ay_address = ay_address_r;
    assign ay_data    = ay_data_r;
    assign ay_wren    = ay_wren_r;
    assign busy       = (state_r != IDLE) || !empty_s;
    assign full       = full_s;
    assign overflow   = overflow_r;

    // Queue storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 12'h000;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r[FIFO_AW-1:0]] <= {wr_reg, wr_val};
        end
    end

    // Queue pointers and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (wr_stb && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // FSM state, ce counter, bus outputs and popped entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            ay_address_r <= 2'b00;
            ay_data_r    <= 8'h00;
            ay_wren_r    <= 1'b0;
            hold_reg_r   <= 4'h0;
            hold_val_r   <= 8'h00;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            ay_address_r <= addr_nxt_s;
            ay_data_r    <= data_nxt_s;
            ay_wren_r    <= wren_nxt_s;
            if (pop_s) begin
                hold_reg_r <= head_s[11:8];
                hold_val_r <= head_s[7:0];
            end
        end
    end

    // Next-state logic; bus outputs only change on the clk that enters a new state
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pop_s       = 1'b0;
        shadow_we_s = 1'b0;
        addr_nxt_s  = ay_address_r;
        data_nxt_s  = ay_data_r;
        wren_nxt_s  = ay_wren_r;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = LATCH;
                    cnt_nxt_s   = 4'd0;
                    addr_nxt_s  = 2'b01;
                    data_nxt_s  = {4'h0, head_s[11:8]};
                    wren_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LATCH: begin
                if (hold_done_s) begin
                    state_nxt_s = GAP1;
                    cnt_nxt_s   = 4'd0;
                    wren_nxt_s  = 1'b0;
                end else if (ce) begin
                    cnt_nxt_s = cnt_r + 4'd1;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            GAP1: begin
                if (gap_done_s) begin
                    state_nxt_s = WRITE;
                    cnt_nxt_s   = 4'd0;
                    addr_nxt_s  = 2'b00;
                    data_nxt_s  = hold_val_r;
                    wren_nxt_s  = 1'b1;
                end else if (ce) begin
                    cnt_nxt_s = cnt_r + 4'd1;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            WRITE: begin
                if (hold_done_s) begin
                    state_nxt_s = GAP2;
                    cnt_nxt_s   = 4'd0;
                    wren_nxt_s  = 1'b0;
                    shadow_we_s = 1'b1;
                end else if (ce) begin
                    cnt_nxt_s = cnt_r + 4'd1;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            GAP2: begin
                if (gap_done_s) begin
                    cnt_nxt_s = 4'd0;
                    if (!empty_s) begin
                        pop_s       = 1'b1;
                        state_nxt_s = LATCH;
                        addr_nxt_s  = 2'b01;
                        data_nxt_s  = {4'h0, head_s[11:8]};
                        wren_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (ce) begin
                    cnt_nxt_s = cnt_r + 4'd1;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
                wren_nxt_s  = 1'b0;
            end
        endcase
    end

    // Shadow of last value issued per register, plus registered readback
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                shadow_r[i] <= 8'h00;
            end
            rd_val_r <= 8'h00;
        end else begin
            if (shadow_we_s) begin
                shadow_r[hold_reg_r] <= hold_val_r;
            end
            rd_val_r <= shadow_r[rd_reg];
        end
    end

endmodule

// File: tb/tb_ay_bus_writer.sv
// Scoreboard bench for ay_bus_writer: expected bus phases are queued at enqueue time and
// matched by a monitor on every rising ay_wren; a second instance covers HOLD_CE=3/GAP_CE=0.
module tb_ay_bus_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic       wr_stb = 1'b0;
    logic       wr_stb_b = 1'b0;
    logic [3:0] wr_reg = 4'h0;
    logic [7:0] wr_val = 8'h00;
    logic [3:0] rd_reg = 4'h0;
    logic [7:0] rd_val, ay_data, rd_val_b, ay_data_b;
    logic [1:0] ay_address, ay_address_b;
    logic       ay_wren, busy, full, overflow;
    logic       ay_wren_b, busy_b, full_b, overflow_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ce_per = 0;
    bit ce_auto = 1'b1;
    bit b2b_chk = 1'b0;
    int last_latch = -1;
    logic [9:0] exp_q[$];

    ay_bus_writer #(.FIFO_AW(4), .HOLD_CE(1), .GAP_CE(1)) u_dut_a (
        .clk(clk), .reset(reset), .ce(ce), .wr_stb(wr_stb), .wr_reg(wr_reg), .wr_val(wr_val),
        .rd_reg(rd_reg), .rd_val(rd_val), .ay_address(ay_address), .ay_data(ay_data),
        .ay_wren(ay_wren), .busy(busy), .full(full), .overflow(overflow)
    );

    ay_bus_writer #(.FIFO_AW(2), .HOLD_CE(3), .GAP_CE(0)) u_dut_b (
        .clk(clk), .reset(reset), .ce(ce), .wr_stb(wr_stb_b), .wr_reg(wr_reg), .wr_val(wr_val),
        .rd_reg(rd_reg), .rd_val(rd_val_b), .ay_address(ay_address_b), .ay_data(ay_data_b),
        .ay_wren(ay_wren_b), .busy(busy_b), .full(full_b), .overflow(overflow_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Periodic ce, driven 2 ns after the edge so it is stable at the next one
    always @(posedge clk) begin
        #2;
        if (ce_auto) ce = (ce_per != 0) && (cyc % ce_per == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor for instance A: match each phase start against the scoreboard queue
    logic prev_wren = 1'b0;
    int   ce_cnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_wren = 1'b0;
            ce_cnt = 0;
        end else begin
            if (ay_wren && !prev_wren) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_phase", {22'h0, ay_address, ay_data}, 32'h3FF);
                end else begin
                    chk("phase_addr_data", {22'h0, ay_address, ay_data}, {22'h0, exp_q.pop_front()});
                end
                if (ay_address == 2'b01) begin
                    if (b2b_chk && last_latch >= 0) chk("b2b_latch_spacing", cyc - last_latch, 4);
                    last_latch = cyc;
                end
                ce_cnt = int'(ce);
            end else if (ay_wren) begin
                ce_cnt += int'(ce);
            end else if (prev_wren) begin
                chk("phase_ce_count", ce_cnt, 1);
            end
            prev_wren = ay_wren;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [3:0] r, input logic [7:0] v, input bit expect_issue);
        wr_reg = r;
        wr_val = v;
        wr_stb = 1'b1;
        if (expect_issue) begin
            exp_q.push_back({2'b01, 4'h0, r});
            exp_q.push_back({2'b00, v});
        end
        tick();
        wr_stb = 1'b0;
    endtask

    task automatic pulse_ce();
        ce = 1'b1;
        tick();
        ce = 1'b0;
    endtask

    task automatic check_rd(input logic [3:0] r, input logic [7:0] v, input string name);
        rd_reg = r;
        tick();
        chk(name, rd_val, v);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        chk(name, (n < limit) ? 0 : 1, 0);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  phase, cnt, gap;
        bit  seen, ok;
        #13;
        // Reset values while reset is held
        chk("rst_address", ay_address, 2'b00);
        chk("rst_data", ay_data, 8'h00);
        chk("rst_wren", ay_wren, 1'b0);
        chk("rst_rd_val", rd_val, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // T1: single write, ce every 4 clk
        ce_per = 4;
        rd_reg = 4'd7;
        push(4'd7, 8'h38, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ay_wren && ay_address == 2'b00) seen = 1'b1;
            if (seen && !ay_wren) break;
        end
        chk("t1_write_seen", seen, 1'b1);
        chk("t1_rd_old_same_clk", rd_val, 8'h00);
        @(negedge clk);
        chk("t1_rd_new_next_clk", rd_val, 8'h38);
        tick();
        wait_idle(100, "t1_idle");

        // T2/T3: stall one entry in LATCH, burst 16, then overflow
        ce_per = 0;
        tick();
        push(4'd0, 8'h10, 1'b1);
        tick();
        for (int i = 0; i < 16; i++) push(4'(i), 8'h80 + 8'(i), 1'b1);
        chk("t2_full", full, 1'b1);
        chk("t2_no_overflow", overflow, 1'b0);
        chk("t2_busy", busy, 1'b1);
        push(4'd3, 8'hAA, 1'b0);
        chk("t3_overflow", overflow, 1'b1);
        chk("t3_still_full", full, 1'b1);
        last_latch = -1;
        b2b_chk = 1'b1;
        ce_per = 1;
        wait_idle(400, "t2_idle");
        b2b_chk = 1'b0;
        chk("t2_not_full", full, 1'b0);
        check_rd(4'd3, 8'h83, "t3_shadow3");
        check_rd(4'd0, 8'h80, "t2_shadow0");
        check_rd(4'd14, 8'h8E, "t2_shadow14");
        check_rd(4'd15, 8'h8F, "t2_shadow15");

        // T4: stall ce for 100 clk during WRITE
        ce_per = 0;
        tick();
        ce_auto = 1'b0;
        ce = 1'b0;
        push(4'd5, 8'h5A, 1'b1);
        tick();
        pulse_ce();
        pulse_ce();
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!(ay_wren == 1'b1 && ay_address == 2'b00 && ay_data == 8'h5A)) ok = 1'b0;
            tick();
        end
        chk("t4_stable", ok, 1'b1);
        pulse_ce();
        chk("t4_resume_wren", ay_wren, 1'b0);
        pulse_ce();
        chk("t4_idle", busy, 1'b0);
        check_rd(4'd5, 8'h5A, "t4_shadow5");

        // T6: instance B, HOLD_CE=3, GAP_CE=0, ce every 2 clk
        ce_auto = 1'b1;
        ce_per = 2;
        wr_reg = 4'd14;
        wr_val = 8'hC5;
        wr_stb_b = 1'b1;
        tick();
        wr_stb_b = 1'b0;
        phase = 0;
        cnt = 0;
        gap = 0;
        for (int i = 0; i < 200 && phase < 5; i++) begin
            @(negedge clk);
            case (phase)
                0: if (ay_wren_b) begin
                    chk("t6_latch", {ay_address_b, ay_data_b}, {2'b01, 8'h0E});
                    cnt = int'(ce);
                    phase = 1;
                end
                1: if (ay_wren_b) cnt += int'(ce);
                   else begin chk("t6_latch_ce", cnt, 3); gap = 1; phase = 2; end
                2: if (!ay_wren_b) gap++;
                   else begin
                       chk("t6_gap1_len", gap, 1);
                       chk("t6_write", {ay_address_b, ay_data_b}, {2'b00, 8'hC5});
                       cnt = int'(ce);
                       phase = 3;
                   end
                3: if (ay_wren_b) cnt += int'(ce);
                   else begin chk("t6_write_ce", cnt, 3); gap = int'(busy_b); phase = 4; end
                4: if (busy_b) gap++;
                   else begin chk("t6_gap2_len", gap, 1); phase = 5; end
                default: phase = 5;
            endcase
        end
        chk("t6_complete", phase, 5);
        tick();
        rd_reg = 4'd14;
        tick();
        chk("t6_shadow14", rd_val_b, 8'hC5);

        // T5: reset in the middle of WRITE with a second entry queued
        ce_auto = 1'b0;
        ce = 1'b0;
        tick();
        push(4'd9, 8'h99, 1'b1);
        push(4'd10, 8'h11, 1'b1);
        tick();
        pulse_ce();
        pulse_ce();
        chk("t5_in_write", {ay_wren, ay_address, ay_data}, {1'b1, 2'b00, 8'h99});
        reset = 1'b1;
        #1;
        chk("t5_wren_drop", ay_wren, 1'b0);
        chk("t5_busy", busy, 1'b0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        ce_auto = 1'b1;
        ce_per = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("t5_no_replay", busy, 1'b0);
        chk("t5_overflow_cleared", overflow, 1'b0);
        check_rd(4'd9, 8'h00, "t5_shadow9");
        check_rd(4'd10, 8'h00, "t5_shadow10");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
